// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory port arbiter.
`timescale 1ns/1ps
package dmem_arb_pkg;

  // Widths the arbiter is built for: a 128-bit RAM line holding four 32-bit words.
  localparam int WORD_W_P = 32;
  localparam int LINE_W_P = 128;
  localparam int LANES    = LINE_W_P / WORD_W_P;
  localparam int BE_W     = LINE_W_P / 8;
  localparam int LANE_W   = $clog2(LANES);

  // Owner tag carried down the read-return pipeline.
  localparam logic OWN_S = 1'b0;
  localparam logic OWN_V = 1'b1;

  // Which requester wins the next simultaneous request.
  typedef enum logic {
    PRI_S = 1'b0,
    PRI_V = 1'b1
  } pri_e;

  // One in-flight read: who asked for it and which scalar lane to pick.
  typedef struct packed {
    logic              valid;
    logic              owner;
    logic [LANE_W-1:0] lane;
  } ret_entry_t;

endpackage

// File: rtl/rd_return_pipe.sv
// Fixed-latency read-return tracker. A granted read enters stage 0; when it
// reaches the last stage the RAM data is valid and is routed to its owner.
//
// Handshake: o_s_rvalid / o_v_rvalid are single-cycle pulses with no
// backpressure. During the pulse the rdata output carries the returning data
// directly; the value is captured in a register at the same edge and held
// until the next pulse for that owner.
`timescale 1ns/1ps
module rd_return_pipe
  import dmem_arb_pkg::*;
#(
  parameter int RD_LAT = 1,
  parameter int WORD_W = 32,
  parameter int LINE_W = 128
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_load,
  input  logic              i_owner,
  input  logic [LANE_W-1:0] i_lane,
  input  logic [LINE_W-1:0] i_mem_rdata,
  output logic              o_s_rvalid,
  output logic [WORD_W-1:0] o_s_rdata,
  output logic              o_v_rvalid,
  output logic [LINE_W-1:0] o_v_rdata
);

  ret_entry_t        r_pipe [RD_LAT];
  ret_entry_t        w_out;
  logic [WORD_W-1:0] w_slice;
  logic [WORD_W-1:0] r_s_rdata;
  logic [LINE_W-1:0] r_v_rdata;

  assign w_out      = r_pipe[RD_LAT-1];
  assign w_slice    = i_mem_rdata[w_out.lane * WORD_W +: WORD_W];
  assign o_s_rvalid = w_out.valid & (w_out.owner == OWN_S);
  assign o_v_rvalid = w_out.valid & (w_out.owner == OWN_V);
  assign o_s_rdata  = o_s_rvalid ? w_slice : r_s_rdata;
  assign o_v_rdata  = o_v_rvalid ? i_mem_rdata : r_v_rdata;

  // Shift in-flight read tags one stage per cycle; reset drops them all.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < RD_LAT; k++) r_pipe[k] <= '0;
    end else begin
      r_pipe[0].valid <= i_load;
      r_pipe[0].owner <= i_owner;
      r_pipe[0].lane  <= i_lane;
      for (int k = 1; k < RD_LAT; k++) r_pipe[k] <= r_pipe[k-1];
    end
  end

  // Hold the last returned data per owner between return pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s_rdata <= '0;
      r_v_rdata <= '0;
    end else begin
      if (o_s_rvalid) r_s_rdata <= w_slice;
      if (o_v_rvalid) r_v_rdata <= i_mem_rdata;
    end
  end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Round-robin arbiter sharing one 128-bit single-port data RAM between the
// 32-bit scalar and 128-bit vector load/store paths.
//
// Handshake: a requester raises req with its fields stable and keeps them
// stable until gnt. gnt is combinational in the request cycle; the RAM is
// accessed in that same cycle. stall = req & ~gnt and is the memory-stage
// stall for the losing side. Reads return as a one-cycle rvalid pulse
// RD_LAT cycles after the grant; writes never return anything.
`timescale 1ns/1ps
module dmem_port_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int WORD_W = 32,
  parameter int LINE_W = 128,
  parameter int RD_LAT = 1,
  parameter int CNT_W  = 16
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   s_req,
  input  logic                                   s_we,
  input  logic [ADDR_W-1:0]                      s_addr,
  input  logic [WORD_W-1:0]                      s_wdata,
  output logic                                   s_gnt,
  output logic                                   s_stall,
  output logic                                   s_rvalid,
  output logic [WORD_W-1:0]                      s_rdata,
  input  logic                                   v_req,
  input  logic                                   v_we,
  input  logic [ADDR_W-1:0]                      v_addr,
  input  logic [LINE_W-1:0]                      v_wdata,
  output logic                                   v_gnt,
  output logic                                   v_stall,
  output logic                                   v_rvalid,
  output logic [LINE_W-1:0]                      v_rdata,
  output logic                                   mem_en,
  output logic                                   mem_we,
  output logic [ADDR_W-$clog2(LINE_W/8)-1:0]     mem_addr,
  output logic [LINE_W/8-1:0]                    mem_be,
  output logic [LINE_W-1:0]                      mem_wdata,
  input  logic [LINE_W-1:0]                      mem_rdata,
  output logic [CNT_W-1:0]                       conflict_cnt,
  output pri_e                                   dbg_state
);

  localparam int OFF_W   = $clog2(LINE_W / 8);
  localparam int WB      = WORD_W / 8;
  localparam int WB_SH   = $clog2(WB);
  localparam int L_LANES = LINE_W / WORD_W;
  localparam int BEW     = LINE_W / 8;

  pri_e              r_state;
  logic [CNT_W-1:0]  r_conflict_cnt;
  logic              w_s_gnt;
  logic              w_v_gnt;
  logic              w_rd_load;
  logic [LANE_W-1:0] w_lane;
  logic [BEW-1:0]    w_s_be;

  // Scalar lane inside the line and its write byte-enable pattern.
  assign w_lane = s_addr[WB_SH +: LANE_W];
  assign w_s_be = {{(BEW-WB){1'b0}}, {WB{1'b1}}} << (WB * w_lane);

  // Grant: the priority holder wins a conflict, a lone requester always wins.
  always_comb begin
    w_s_gnt = 1'b0;
    w_v_gnt = 1'b0;
    if (!reset) begin
      if (s_req && v_req) begin
        w_s_gnt = (r_state == PRI_S);
        w_v_gnt = (r_state == PRI_V);
      end else begin
        w_s_gnt = s_req;
        w_v_gnt = v_req;
      end
    end
  end

  // RAM port mux; idle cycles present the scalar-side address/data.
  always_comb begin
    mem_en    = w_s_gnt | w_v_gnt;
    mem_we    = 1'b0;
    mem_be    = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (!reset) begin
      mem_addr  = s_addr[ADDR_W-1:OFF_W];
      mem_wdata = {L_LANES{s_wdata}};
      if (w_v_gnt) begin
        mem_we    = v_we;
        mem_be    = '1;
        mem_addr  = v_addr[ADDR_W-1:OFF_W];
        mem_wdata = v_wdata;
      end else if (w_s_gnt) begin
        mem_we = s_we;
        mem_be = s_we ? w_s_be : '0;
      end
    end
  end

  // Priority FSM: after any grant the other side gets priority; idle holds.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= PRI_S;
    end else if (w_s_gnt) begin
      r_state <= PRI_V;
    end else if (w_v_gnt) begin
      r_state <= PRI_S;
    end
  end

  // Count cycles where both sides want the RAM, sticking at all-ones.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_conflict_cnt <= '0;
    end else if (s_req && v_req && (r_conflict_cnt != {CNT_W{1'b1}})) begin
      r_conflict_cnt <= r_conflict_cnt + 1'b1;
    end
  end

  assign w_rd_load    = mem_en & ~mem_we;
  assign s_gnt        = w_s_gnt;
  assign v_gnt        = w_v_gnt;
  assign s_stall      = s_req & ~w_s_gnt & ~reset;
  assign v_stall      = v_req & ~w_v_gnt & ~reset;
  assign conflict_cnt = r_conflict_cnt;
  assign dbg_state    = r_state;

  rd_return_pipe #(
    .RD_LAT (RD_LAT),
    .WORD_W (WORD_W),
    .LINE_W (LINE_W)
  ) u_ret (
    .clk         (clk),
    .reset       (reset),
    .i_load      (w_rd_load),
    .i_owner     (w_v_gnt ? OWN_V : OWN_S),
    .i_lane      (w_lane),
    .i_mem_rdata (mem_rdata),
    .o_s_rvalid  (s_rvalid),
    .o_s_rdata   (s_rdata),
    .o_v_rvalid  (v_rvalid),
    .o_v_rdata   (v_rdata)
  );

endmodule
